// File: rtl/dsp_mac_seq_if.sv
// dsp_mac_seq_if: operand stream, DSP48A1 slice drive/return and result stream of the MAC sequencer.
interface dsp_mac_seq_if;
  logic        s_valid;
  logic        s_ready;
  logic [17:0] s_a;
  logic [17:0] s_b;
  logic [17:0] dsp_a;
  logic [17:0] dsp_b;
  logic [17:0] dsp_d;
  logic [7:0]  dsp_opmode;
  logic [47:0] dsp_p;
  logic        m_valid;
  logic        m_ready;
  logic [47:0] m_data;
  modport master (
    output s_valid, s_a, s_b, m_ready, dsp_p,
    input  s_ready, dsp_a, dsp_b, dsp_d, dsp_opmode, m_valid, m_data
  );
  modport slave (
    input  s_valid, s_a, s_b, m_ready, dsp_p,
    output s_ready, dsp_a, dsp_b, dsp_d, dsp_opmode, m_valid, m_data
  );
endinterface

// File: rtl/dsp_mac_seq.sv
// dsp_mac_seq: feeds operand pairs into a DSP48A1 slice and returns each N_TAPS dot product.
module dsp_mac_seq #(
  parameter int N_TAPS   = 8,
  parameter int PIPE_LAT = 3,
  parameter int OPM_DLY  = 1
) (
  input logic           clk,
  input logic           rst,
  dsp_mac_seq_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;
  localparam int TW = $clog2(N_TAPS + 1);
  localparam int DL = PIPE_LAT + OPM_DLY;
  localparam int DW = $clog2(DL + 1);
  localparam logic [TW-1:0] TAP_LAST = TW'(N_TAPS - 1);
  localparam logic [DW-1:0] DRN_LAST = DW'(DL - 1);
  localparam logic [7:0] OPM_FIRST = 8'h01;
  localparam logic [7:0] OPM_ACC   = 8'h09;
  localparam logic [7:0] OPM_BUB   = 8'h08;
  state_t          state_q, state_d;
  logic [TW-1:0]   tap_cnt_q, tap_cnt_d;
  logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
  logic [17:0]     a_q, a_d, b_q, b_d;
  logic [7:0]      opm_d;
  // opm_q[0] issues alongside dsp_a/dsp_b; the remaining OPM_DLY stages add the lag
  logic [7:0]      opm_q [OPM_DLY+1];
  logic            m_valid_q, m_valid_d;
  logic [47:0]     m_data_q, m_data_d;
  logic            accept, drain_done;
  assign bus.s_ready    = !rst && (state_q == IDLE || state_q == ACCUM);
  assign accept         = bus.s_valid && bus.s_ready;
  assign drain_done     = state_q == DRAIN && drain_cnt_q == DRN_LAST;
  assign bus.dsp_a      = a_q;
  assign bus.dsp_b      = b_q;
  assign bus.dsp_d      = '0;
  assign bus.dsp_opmode = opm_q[OPM_DLY];
  assign bus.m_valid    = m_valid_q;
  assign bus.m_data     = m_data_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tap_cnt_q   <= '0;
      drain_cnt_q <= '0;
      a_q         <= '0;
      b_q         <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      for (int i = 0; i <= OPM_DLY; i++) opm_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      tap_cnt_q   <= tap_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      opm_q[0]    <= opm_d;
      for (int i = 1; i <= OPM_DLY; i++) opm_q[i] <= opm_q[i-1];
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = accept ? (N_TAPS == 1 ? DRAIN : ACCUM) : IDLE;
      ACCUM: state_d = accept && tap_cnt_q == TAP_LAST ? DRAIN : ACCUM;
      DRAIN: state_d = drain_done ? HOLD : DRAIN;
      HOLD:  state_d = m_valid_q && bus.m_ready ? IDLE : HOLD;
    endcase
  end
  // the first tap of a group always uses Z=0 so stale P never leaks into a new sum
  always_comb begin
    a_d         = accept ? bus.s_a : '0;
    b_d         = accept ? bus.s_b : '0;
    opm_d       = !accept ? OPM_BUB : state_q == IDLE ? OPM_FIRST : OPM_ACC;
    tap_cnt_d   = !accept ? tap_cnt_q : state_q == IDLE ? TW'(1) : tap_cnt_q + 1'b1;
    drain_cnt_d = state_q == DRAIN ? drain_cnt_q + 1'b1 : '0;
    m_valid_d   = drain_done || (m_valid_q && !bus.m_ready);
    m_data_d    = drain_done ? bus.dsp_p : m_data_q;
  end
endmodule

// File: tb/tb_dsp_mac_seq.sv
// tb_dsp_mac_seq: drives two sequencers (N_TAPS=4 and 1) against a behavioural DSP48A1 slice.
module tb_dsp_mac_seq;
  localparam int N4  = 4;
  localparam int LAT = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [47:0] got4 [$];
  always #5 clk = ~clk;
  dsp_mac_seq_if bus4 ();
  dsp_mac_seq_if bus1 ();
  dsp_mac_seq #(.N_TAPS(4), .PIPE_LAT(3), .OPM_DLY(1)) u4 (.clk(clk), .rst(rst), .bus(bus4));
  dsp_mac_seq #(.N_TAPS(1), .PIPE_LAT(3), .OPM_DLY(1)) u1 (.clk(clk), .rst(rst), .bus(bus1));
  // slice: A/B reg, M reg, P reg; opmode sampled one stage before P
  logic signed [47:0] m4a = '0, m4b = '0, p4 = '0, m1a = '0, m1b = '0, p1 = '0;
  logic [7:0] o4 = '0, o1 = '0;
  always @(posedge clk) begin
    m4a <= 48'($signed(bus4.dsp_a)) * 48'($signed(bus4.dsp_b));
    m4b <= m4a;
    o4  <= bus4.dsp_opmode;
    p4  <= (o4[1:0] == 2'b01 ? m4b : 48'sd0) + (o4[3:2] == 2'b10 ? p4 : 48'sd0);
    m1a <= 48'($signed(bus1.dsp_a)) * 48'($signed(bus1.dsp_b));
    m1b <= m1a;
    o1  <= bus1.dsp_opmode;
    p1  <= (o1[1:0] == 2'b01 ? m1b : 48'sd0) + (o1[3:2] == 2'b10 ? p1 : 48'sd0);
  end
  assign bus4.dsp_p = p4;
  assign bus1.dsp_p = p1;
  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // transaction-level model: group sums, result after LAT edges, held until taken
  int     cnt = 0, cd = 0;
  longint sum = 0, ed = 0;
  bit     ev = 0, busy = 0, acc;
  always @(posedge clk) begin
    if (rst) begin
      cnt = 0; sum = 0; cd = 0; ev = 0; busy = 0;
    end else begin
      acc = !busy && bus4.s_valid;
      if (ev && bus4.m_ready) begin ev = 0; busy = 0; end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin ev = 1; ed = sum; end
      end
      if (acc) begin
        sum = (cnt == 0 ? 0 : sum) + longint'($signed(bus4.s_a)) * longint'($signed(bus4.s_b));
        cnt++;
        if (cnt == N4) begin cnt = 0; busy = 1; cd = LAT; end
      end
    end
    #1;
    chk("model_s_ready", 48'(bus4.s_ready), 48'(!rst && !busy));
    chk("model_m_valid", 48'(bus4.m_valid), 48'(ev));
    if (ev) chk("model_m_data", bus4.m_data, ed[47:0]);
  end
  always @(posedge clk) if (!rst && bus4.m_valid && bus4.m_ready) got4.push_back(bus4.m_data);
  function automatic logic [47:0] res(input int i);
    return got4.size() > i ? got4[i] : 48'hx;
  endfunction
  task automatic send4(input int a, input int b);
    int n = 0;
    bus4.s_valid = 1'b1;
    bus4.s_a = 18'(a);
    bus4.s_b = 18'(b);
    while (!bus4.s_ready && n < 200) begin @(negedge clk); n++; end
    if (n == 200) chk("send_timeout", 48'(bus4.s_ready), 48'd1);
    @(negedge clk);
    bus4.s_valid = 1'b0;
  endtask
  task automatic wait_res(input int n);
    int k = 0;
    while (got4.size() < n && k < 200) begin @(negedge clk); k++; end
    if (got4.size() < n) chk("result_timeout", 48'(got4.size()), 48'(n));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus4.s_valid = 0; bus4.s_a = '0; bus4.s_b = '0; bus4.m_ready = 1;
    bus1.s_valid = 0; bus1.s_a = '0; bus1.s_b = '0; bus1.m_ready = 1;
    repeat (3) @(negedge clk);
    chk("rst_opmode", 48'(bus4.dsp_opmode), 48'h00);
    chk("rst_dsp_a", 48'(bus4.dsp_a), 48'd0);
    chk("rst_m_valid", 48'(bus4.m_valid), 48'd0);
    chk("rst_m_data", bus4.m_data, 48'd0);
    chk("rst_s_ready", 48'(bus4.s_ready), 48'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_s_ready", 48'(bus4.s_ready), 48'd1);
    send4(1, 2); send4(3, 4); send4(-5, 6); send4(7, 8);
    repeat (3) @(negedge clk);
    chk("lat_before", 48'(bus4.m_valid), 48'd0);
    @(negedge clk);
    chk("lat_rise", 48'(bus4.m_valid), 48'd1);
    chk("dot_40", bus4.m_data, 48'd40);
    @(negedge clk);
    chk("one_cycle", 48'(bus4.m_valid), 48'd0);
    send4(1, 2); send4(3, 4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("gap_opmode", 48'(bus4.dsp_opmode), i == 0 ? 48'h09 : 48'h08);
    end
    send4(-5, 6); send4(7, 8);
    wait_res(2);
    chk("stall_40", res(1), 48'd40);
    bus4.m_ready = 0;
    for (int i = 0; i < 4; i++) send4(1, 1);
    for (int k = 0; k < 200 && !bus4.m_valid; k++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("hold_s_ready", 48'(bus4.s_ready), 48'd0);
      chk("hold_m_valid", 48'(bus4.m_valid), 48'd1);
      chk("hold_m_data", bus4.m_data, 48'd4);
      @(negedge clk);
    end
    bus4.m_ready = 1;
    for (int i = 0; i < 4; i++) send4(2, 3);
    wait_res(4);
    chk("grp1_4", res(2), 48'd4);
    chk("grp2_24", res(3), 48'd24);
    for (int i = 0; i < 4; i++) send4(-131072, -131072);
    wait_res(5);
    chk("max_2pow36", res(4), 48'h10_0000_0000);
    send4(1, 2); send4(3, 4);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_opmode", 48'(bus4.dsp_opmode), 48'h00);
    chk("abort_m_valid", 48'(bus4.m_valid), 48'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_no_result", 48'(got4.size()), 48'd5);
    send4(1, 2); send4(3, 4); send4(-5, 6); send4(7, 8);
    wait_res(6);
    chk("after_abort_40", res(5), 48'd40);
    chk("n1_s_ready_idle", 48'(bus1.s_ready), 48'd1);
    bus1.s_valid = 1; bus1.s_a = 18'(-3); bus1.s_b = 18'(7);
    @(negedge clk);
    bus1.s_valid = 0;
    chk("n1_drain_s_ready", 48'(bus1.s_ready), 48'd0);
    repeat (3) @(negedge clk);
    chk("n1_lat_before", 48'(bus1.m_valid), 48'd0);
    @(negedge clk);
    chk("n1_lat_rise", 48'(bus1.m_valid), 48'd1);
    chk("n1_minus21", bus1.m_data, 48'hFFFF_FFFF_FFEB);
    @(negedge clk);
    chk("n1_done", 48'(bus1.m_valid), 48'd0);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
